// File: rtl/serial_subtractor_ctrl.sv
// Bit-serial a-b: one subtractor cell walked LSB-first over WIDTH cycles; optional ovf via SERIAL_SUB_OVF_EN.
// Latency: WIDTH+1 cycles from the accepting edge to the done pulse; one op per WIDTH+2 cycles.
// Backpressure: none; start is only honoured in IDLE and is dropped (not queued) while busy.
module serial_subtractor_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] diff,
    output logic             borr,
    output logic             busy,
    output logic             done
`ifdef SERIAL_SUB_OVF_EN
    ,
    output logic             ovf
`endif
);

    // Counter must be able to hold WIDTH so it never wraps mid-operation.
    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             br_q, br_d;
    logic             borr_q, borr_d;

    // Single subtractor cell and the result register shifted by one bit.
    logic             bit_d;
    logic             bit_bo;
    logic [WIDTH-1:0] res_shift;

`ifdef SERIAL_SUB_OVF_EN
    logic a_msb_q, a_msb_d;
    logic b_msb_q, b_msb_d;
    logic ovf_q, ovf_d;
`endif

    // Next-state, datapath sequencing and the one-bit subtractor cell.
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        diff_d  = diff_q;
        cnt_d   = cnt_q;
        br_d    = br_q;
        borr_d  = borr_q;
`ifdef SERIAL_SUB_OVF_EN
        a_msb_d = a_msb_q;
        b_msb_d = b_msb_q;
        ovf_d   = ovf_q;
`endif

        bit_d     = a_q[0] ^ b_q[0] ^ br_q;
        bit_bo    = (~a_q[0] & b_q[0]) | (~(a_q[0] ^ b_q[0]) & br_q);
        // Result fills from the MSB side so the LSB ends up at bit 0.
        res_shift = res_q >> 1;
        res_shift[WIDTH-1] = bit_d;

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    a_d     = a;
                    b_d     = b;
                    res_d   = '0;
                    br_d    = 1'b0;
                    cnt_d   = '0;
                    state_d = S_RUN;
`ifdef SERIAL_SUB_OVF_EN
                    a_msb_d = a[WIDTH-1];
                    b_msb_d = b[WIDTH-1];
`endif
                end
            end
            S_RUN: begin
                res_d = res_shift;
                a_d   = a_q >> 1;
                b_d   = b_q >> 1;
                br_d  = bit_bo;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == LAST_BIT) begin
                    // Publish results only here so they hold across the next operation.
                    diff_d  = res_shift;
                    borr_d  = bit_bo;
                    state_d = S_DONE;
`ifdef SERIAL_SUB_OVF_EN
                    // The final cell output is the MSB of the difference.
                    ovf_d = (a_msb_q != b_msb_q) & (bit_d != a_msb_q);
`endif
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset clears everything including published results.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            diff_q  <= '0;
            cnt_q   <= '0;
            br_q    <= 1'b0;
            borr_q  <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
            a_msb_q <= 1'b0;
            b_msb_q <= 1'b0;
            ovf_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            diff_q  <= diff_d;
            cnt_q   <= cnt_d;
            br_q    <= br_d;
            borr_q  <= borr_d;
`ifdef SERIAL_SUB_OVF_EN
            a_msb_q <= a_msb_d;
            b_msb_q <= b_msb_d;
            ovf_q   <= ovf_d;
`endif
        end
    end

    assign diff = diff_q;
    assign borr = borr_q;
    assign busy = (state_q != S_IDLE);
    assign done = (state_q == S_DONE);
`ifdef SERIAL_SUB_OVF_EN
    assign ovf  = ovf_q;
`endif

endmodule

// File: tb/tb_serial_subtractor_ctrl.sv
// Bench for serial_subtractor_ctrl at WIDTH=8: vector table plus scoreboard-checked sequences.
// Results are compared whenever done is seen; a done with nothing expected is an error.
// Build with SERIAL_SUB_OVF_EN defined to also check the ovf output.
module tb_serial_subtractor_ctrl;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic [W-1:0] diff;
    logic         borr;
    logic         busy;
    logic         done;
`ifdef SERIAL_SUB_OVF_EN
    logic         ovf;
`endif

    serial_subtractor_ctrl #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .diff  (diff),
        .borr  (borr),
        .busy  (busy),
        .done  (done)
`ifdef SERIAL_SUB_OVF_EN
        ,
        .ovf   (ovf)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] d;
        logic         br;
        logic         ov;
    } vec_t;

    vec_t         vecs [9];
    vec_t         sb [$];
    int           total = 0;
    int           bad = 0;
    int           cyc = 0;
    logic         stab_en = 1'b0;
    logic [W-1:0] diff_hold = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic vec_t model(input logic [W-1:0] x, input logic [W-1:0] y);
        vec_t m;
        m.a  = x;
        m.b  = y;
        m.d  = x - y;
        m.br = (x < y);
        m.ov = (x[W-1] != y[W-1]) && (m.d[W-1] != x[W-1]);
        return m;
    endfunction

    // One clock: sample 1 time unit after the edge, scoreboard on done, stability between dones.
    task automatic tick();
        vec_t e;
        @(posedge clk);
        #1;
        cyc++;
        if (done) begin
            if (sb.size() == 0) begin
                check("spurious_done", 64'(done), 64'd0);
            end else begin
                e = sb.pop_front();
                check("diff", 64'(diff), 64'(e.d));
                check("borr", 64'(borr), 64'(e.br));
`ifdef SERIAL_SUB_OVF_EN
                check("ovf", 64'(ovf), 64'(e.ov));
`endif
            end
            diff_hold = diff;
        end else if (stab_en) begin
            check("diff_stable", 64'(diff), 64'(diff_hold));
        end
    endtask

    // Issue one operation from IDLE and check latency to done (accepting edge counted as 1).
    task automatic run_op(input vec_t v);
        int n;
        n = 0;
        while (busy && n < 20) begin
            tick();
            n++;
        end
        a = v.a;
        b = v.b;
        start = 1'b1;
        sb.push_back(v);
        tick();
        start = 1'b0;
        a = $urandom;
        b = $urandom;
        n = 0;
        do begin
            tick();
            n++;
        end while (!done && n < 20);
        check("latency", 64'(n + 1), 64'(W + 1));
        tick();
    endtask

    initial begin
        int n;
        int acc;
        int last_acc;

        vecs[0] = '{8'h05, 8'h03, 8'h02, 1'b0, 1'b0};
        vecs[1] = '{8'h03, 8'h05, 8'hFE, 1'b1, 1'b0};
        vecs[2] = '{8'h00, 8'h00, 8'h00, 1'b0, 1'b0};
        vecs[3] = '{8'h80, 8'h01, 8'h7F, 1'b0, 1'b1};
        vecs[4] = '{8'h7F, 8'hFF, 8'h80, 1'b1, 1'b1};
        vecs[5] = '{8'h00, 8'h01, 8'hFF, 1'b1, 1'b0};
        vecs[6] = '{8'h80, 8'h80, 8'h00, 1'b0, 1'b0};
        vecs[7] = '{8'hA5, 8'h5A, 8'h4B, 1'b0, 1'b1};
        vecs[8] = '{8'h7F, 8'h80, 8'hFF, 1'b1, 1'b1};

        // Reset state, then five idle cycles.
        #2;
        check("rst_diff", 64'(diff), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        tick();
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("idle_busy", 64'(busy), 64'd0);
            check("idle_diff", 64'(diff), 64'd0);
            check("idle_borr", 64'(borr), 64'd0);
`ifdef SERIAL_SUB_OVF_EN
            check("idle_ovf", 64'(ovf), 64'd0);
`endif
        end

        // Table vectors.
        for (int i = 0; i < 9; i++) begin
            run_op(vecs[i]);
        end

        // start held high with fresh operands every cycle.
        diff_hold = diff;
        stab_en = 1'b1;
        acc = 0;
        last_acc = 0;
        n = 0;
        while (acc < 5 && n < 80) begin
            a = $urandom;
            b = $urandom;
            start = 1'b1;
            if (!busy) begin
                sb.push_back(model(a, b));
                if (acc > 0) check("accept_gap", 64'(cyc - last_acc), 64'(W + 2));
                last_acc = cyc;
                acc++;
            end
            tick();
            n++;
        end
        start = 1'b0;
        check("accept_count", 64'(acc), 64'd5);
        n = 0;
        while (sb.size() > 0 && n < 30) begin
            tick();
            n++;
        end
        check("drain", 64'(sb.size()), 64'd0);
        stab_en = 1'b0;
        tick();
        tick();

        // Reset three cycles into RUN; previous diff (0xFF from vecs[8] or random) is overwritten.
        a = 8'h12;
        b = 8'h34;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        tick();
        check("busy_before_rst", 64'(busy), 64'd1);
        rst = 1'b1;
        #1;
        check("arst_busy", 64'(busy), 64'd0);
        check("arst_done", 64'(done), 64'd0);
        check("arst_diff", 64'(diff), 64'd0);
        check("arst_borr", 64'(borr), 64'd0);
`ifdef SERIAL_SUB_OVF_EN
        check("arst_ovf", 64'(ovf), 64'd0);
`endif
        sb.delete();
        tick();
        tick();
        rst = 1'b0;
        for (int i = 0; i < 12; i++) begin
            tick();
        end
        check("post_rst_idle", 64'(busy), 64'd0);
        run_op('{8'hFF, 8'h01, 8'hFE, 1'b0, 1'b0});

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
